// File: rtl/generic_axi_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaiev_bridge_pkg : shared FSM encoding and AXI constants             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package scaiev_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE_R = 2'd1,
        ST_ISSUE_W = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // AxSIZE encoding for a full-width beat of data_w bits
    function automatic logic [2:0] axi_size(input int data_w);
        logic [2:0] size;
        size = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if ((8 << b) <= data_w) size = 3'(b);
        end
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/generic_axi_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | generic_axi_bridge_if : single-beat AXI4 bus between bridge and slave |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface generic_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6
) ();
    logic                  awvalid, awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awcache;
    logic                  wvalid, wready, wlast;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic [ID_W-1:0]       bid;
    logic                  arvalid, arready;
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic                  rvalid, rready, rlast;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic [ID_W-1:0]       rid;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awcache,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arcache, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awcache,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arcache, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface
`default_nettype wire

// File: rtl/generic_axi_bridge_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer moves past the winner |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);
    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_next_ptr;
    int                 w_dist;
    int                 w_best;
    int                 w_win;

    // Winner is the requester closest to the pointer going upward with wrap
    always_comb begin
        w_dist = 0;
        w_best = NUM_PORTS;
        w_win  = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dist = (i + NUM_PORTS - int'(r_ptr)) % NUM_PORTS;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = i;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant[i] = (w_best < NUM_PORTS) && (i == w_win);
        end
        w_next_ptr = c_PTR_W'((w_win + 1) % NUM_PORTS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (|grant) begin
            r_ptr <= w_next_ptr;
        end
    end
endmodule
`default_nettype wire

// File: rtl/generic_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | generic_axi_bridge : NUM_PORTS generic request ports -> AXI4 master   |
// | Option macro: GENERIC_AXI_BRIDGE_RESP_REG_EN (registered read return) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module generic_axi_bridge
    import scaiev_bridge_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            gen_new_request,
    input  logic [NUM_PORTS*ADDR_W-1:0]     gen_addr,
    input  logic [NUM_PORTS-1:0]            gen_re,
    input  logic [NUM_PORTS-1:0]            gen_we,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   gen_be,
    input  logic [NUM_PORTS*DATA_W-1:0]     gen_data_in,
    output logic [NUM_PORTS*DATA_W-1:0]     gen_data_out,
    output logic [NUM_PORTS-1:0]            gen_data_valid,
    output logic [NUM_PORTS-1:0]            gen_ready,
    generic_axi_bridge_if.master            m_axi
);
    localparam int                 c_STRB_W   = DATA_W / 8;
    localparam int                 c_CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [2:0]         c_AXI_SIZE = axi_size(DATA_W);

    logic [NUM_PORTS-1:0] r_buf_valid, r_buf_we, r_dir;
    logic [ADDR_W-1:0]    r_buf_addr [NUM_PORTS];
    logic [c_STRB_W-1:0]  r_buf_be   [NUM_PORTS];
    logic [DATA_W-1:0]    r_buf_data [NUM_PORTS];
    logic [c_CNT_W-1:0]   r_cnt      [NUM_PORTS];
    logic [c_CNT_W-1:0]   w_cnt_next [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_accept, w_eligible, w_req, w_grant;
    logic [NUM_PORTS-1:0] w_rd_hit, w_rd_dec, w_rd_pend, w_wr_dec;

    state_e               r_state;
    logic                 r_arvalid, r_awvalid, r_wvalid;
    logic [ADDR_W-1:0]    r_addr;
    logic [ID_W-1:0]      r_id;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_STRB_W-1:0]  r_wstrb;

    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_data;
    logic [c_STRB_W-1:0]  w_sel_be;
    logic [ID_W-1:0]      w_sel_id;
    logic                 w_sel_we;
    logic                 w_unused_ok;

    // A buffer may only issue in the port's current direction unless it is
    // the sole transaction the port owns, which keeps per-port ordering.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign gen_ready[i]  = rst && !r_buf_valid[i] && (r_cnt[i] < c_CNT_MAX);
        assign w_accept[i]   = gen_new_request[i] && gen_ready[i];
        assign w_eligible[i] = r_buf_valid[i] &&
                               ((r_buf_we[i] == r_dir[i]) || (r_cnt[i] == c_CNT_ONE));
        assign w_rd_hit[i]   = rst && m_axi.rvalid && (m_axi.rid == ID_W'(i)) &&
                               (r_cnt[i] != '0) && !(w_rd_pend[i] && (r_cnt[i] == c_CNT_ONE));
        assign w_wr_dec[i]   = rst && m_axi.bvalid && (m_axi.bid == ID_W'(i)) &&
                               (r_cnt[i] != '0);
    end

    assign w_req = w_eligible & {NUM_PORTS{r_state == ST_IDLE}};

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_req),
        .grant (w_grant)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        w_sel_id   = '0;
        w_sel_we   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = r_buf_addr[i];
                w_sel_data = r_buf_data[i];
                w_sel_be   = r_buf_be[i];
                w_sel_id   = ID_W'(i);
                w_sel_we   = r_buf_we[i];
            end
        end
    end

    // Decrements saturate so stale responses can never wrap the credit
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_accept[i]) w_cnt_next[i] = w_cnt_next[i] + c_CNT_ONE;
            if (w_rd_dec[i] && (w_cnt_next[i] != '0)) w_cnt_next[i] = w_cnt_next[i] - c_CNT_ONE;
            if (w_wr_dec[i] && (w_cnt_next[i] != '0)) w_cnt_next[i] = w_cnt_next[i] - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf_valid <= '0;
            r_buf_we    <= '0;
            r_dir       <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_buf_addr[i] <= '0;
                r_buf_be[i]   <= '0;
                r_buf_data[i] <= '0;
                r_cnt[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_we[i]    <= gen_we[i];
                    r_buf_addr[i]  <= gen_addr[i*ADDR_W +: ADDR_W];
                    r_buf_be[i]    <= gen_be[i*c_STRB_W +: c_STRB_W];
                    r_buf_data[i]  <= gen_data_in[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                    r_dir[i]       <= r_buf_we[i];
                end
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_addr    <= '0;
            r_id      <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_addr  <= w_sel_addr;
                        r_id    <= w_sel_id;
                        r_wdata <= w_sel_data;
                        r_wstrb <= w_sel_be;
                        if (w_sel_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_ISSUE_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_ISSUE_R;
                        end
                    end
                end
                ST_ISSUE_R: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ISSUE_W: begin
                    if (m_axi.awready) r_awvalid <= 1'b0;
                    if (m_axi.wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || m_axi.awready) && (!r_wvalid || m_axi.wready)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef GENERIC_AXI_BRIDGE_RESP_REG_EN
    logic [NUM_PORTS-1:0]        r_data_valid;
    logic [NUM_PORTS*DATA_W-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_valid <= '0;
            r_data_out   <= '0;
        end else begin
            r_data_valid <= w_rd_hit;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_rd_hit[i]) r_data_out[i*DATA_W +: DATA_W] <= m_axi.rdata;
            end
        end
    end

    assign gen_data_valid = r_data_valid;
    assign gen_data_out   = r_data_out;
    assign w_rd_dec       = r_data_valid;
    assign w_rd_pend      = r_data_valid;
`else
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dout
        assign gen_data_out[i*DATA_W +: DATA_W] = w_rd_hit[i] ? m_axi.rdata : '0;
    end

    assign gen_data_valid = w_rd_hit;
    assign w_rd_dec       = w_rd_hit;
    assign w_rd_pend      = '0;
`endif

    assign m_axi.awvalid = r_awvalid;
    assign m_axi.awid    = r_id;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = c_AXI_SIZE;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awcache = CACHE_DEFAULT;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = 1'b1;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.arid    = r_id;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = c_AXI_SIZE;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arcache = CACHE_DEFAULT;
    assign m_axi.rready  = 1'b1;

    // Direction is carried by gen_we alone; response status is not reported
    assign w_unused_ok = ^{gen_re, m_axi.rresp, m_axi.rlast, m_axi.bresp};
endmodule
`default_nettype wire
